// File: rtl/kd_tree_pkg.sv
// Shared definitions for the KD-tree block: default widths reused by the
// controller, the internal nodes and the tree top level, plus the controller
// state encoding.
package kd_tree_pkg;

  localparam int unsigned DATA_WIDTH    = 55;  // 5 x 11-bit patch components
  localparam int unsigned STORAGE_WIDTH = 22;  // node configuration word
  localparam int unsigned NUM_NODES     = 15;  // depth-4 tree

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } kd_state_e;

endpackage

// File: rtl/kd_tree_node_ctrl_onehot_decoder.sv
// onehot_decoder: turns a node index plus a write strobe into a one-hot
// write-enable vector. The output is all-zero when the strobe is low, and at
// most one bit is ever set.
// Ports:
//   idx_i     node index to enable
//   strobe_i  write strobe
//   onehot_o  one-hot enable, NUM_NODES wide
module onehot_decoder #(
  parameter int unsigned NUM_NODES = 15,
  parameter int unsigned IDX_WIDTH = 6
) (
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic                 strobe_i,
  output logic [NUM_NODES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      onehot_o[i] = strobe_i && (idx_i == IDX_WIDTH'(i));
    end
  end

endmodule

// File: rtl/kd_tree_node_ctrl.sv
// kd_tree_node_ctrl: loads the internal nodes of one KD-tree from a
// breadth-first stream of configuration words, then gates query patches to
// the root node. A reload request drains in-flight patches for DRAIN_CYCLES
// before any node is rewritten.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_load_i            (re)load request pulse
//   cfg_valid_i/cfg_data_i  configuration word stream; cfg_ready_o accepts
//   node_wen_o/node_wdata_o one-hot node write enable and shared write data
//   patch_in_valid_i/patch_in_i  query patch; patch_in_ready_o accepts
//   root_valid_o/root_patch_o    patch forwarded to the root node
//   loaded_o                tree fully configured (RUN)
//   busy_o                  loading or draining
module kd_tree_node_ctrl #(
  parameter int unsigned DATA_WIDTH    = kd_tree_pkg::DATA_WIDTH,
  parameter int unsigned STORAGE_WIDTH = kd_tree_pkg::STORAGE_WIDTH,
  parameter int unsigned NUM_NODES     = kd_tree_pkg::NUM_NODES,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned IDX_WIDTH     = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_load_i,
  input  logic                     cfg_valid_i,
  input  logic [STORAGE_WIDTH-1:0] cfg_data_i,
  output logic                     cfg_ready_o,
  output logic [NUM_NODES-1:0]     node_wen_o,
  output logic [STORAGE_WIDTH-1:0] node_wdata_o,
  input  logic                     patch_in_valid_i,
  input  logic [DATA_WIDTH-1:0]    patch_in_i,
  output logic                     patch_in_ready_o,
  output logic                     root_valid_o,
  output logic [DATA_WIDTH-1:0]    root_patch_o,
  output logic                     loaded_o,
  output logic                     busy_o
);

  import kd_tree_pkg::*;

  localparam int unsigned          CntWidth  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDX_WIDTH-1:0] LastIdx   = IDX_WIDTH'(NUM_NODES - 1);
  localparam logic [CntWidth-1:0]  DrainInit = CntWidth'(DRAIN_CYCLES);
  localparam logic [CntWidth-1:0]  DrainLast = CntWidth'(1);

  kd_state_e                state_q;
  logic [IDX_WIDTH-1:0]     node_idx_q;
  logic [CntWidth-1:0]      drain_cnt_q;
  logic                     wr_strobe_q;
  logic [IDX_WIDTH-1:0]     wr_idx_q;
  logic [STORAGE_WIDTH-1:0] wdata_q;
  logic                     root_valid_q;
  logic [DATA_WIDTH-1:0]    root_patch_q;
  logic                     loaded_q;
  logic                     busy_q;

  logic cfg_ready;
  logic patch_ready;
  logic cfg_hs;
  logic patch_hs;

  // Ready signals depend only on state and start_load, never on the valids.
  // A reload request in RUN blocks the patch arriving in the same cycle.
  always_comb begin
    cfg_ready   = (state_q == StLoad);
    patch_ready = (state_q == StRun) && !start_load_i;
    cfg_hs      = cfg_valid_i && cfg_ready;
    patch_hs    = patch_in_valid_i && patch_ready;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      node_idx_q   <= '0;
      drain_cnt_q  <= '0;
      wr_strobe_q  <= 1'b0;
      wr_idx_q     <= '0;
      wdata_q      <= '0;
      root_valid_q <= 1'b0;
      root_patch_q <= '0;
      loaded_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Node write is issued one cycle after the handshake, so the index that
      // was just accepted is captured separately from the running counter.
      wr_strobe_q  <= cfg_hs;
      root_valid_q <= patch_hs;
      if (cfg_hs) begin
        wr_idx_q <= node_idx_q;
        wdata_q  <= cfg_data_i;
      end
      if (patch_hs) begin
        root_patch_q <= patch_in_i;
      end

      case (state_q)
        StIdle: begin
          if (start_load_i) begin
            state_q    <= StLoad;
            node_idx_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        StLoad: begin
          if (cfg_hs) begin
            if (node_idx_q == LastIdx) begin
              state_q    <= StRun;
              node_idx_q <= '0;
              loaded_q   <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              node_idx_q <= node_idx_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (start_load_i) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainInit;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainLast) begin
            state_q     <= StLoad;
            node_idx_q  <= '0;
            drain_cnt_q <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          loaded_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  onehot_decoder #(
    .NUM_NODES(NUM_NODES),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_onehot_decoder (
    .idx_i   (wr_idx_q),
    .strobe_i(wr_strobe_q),
    .onehot_o(node_wen_o)
  );

  assign cfg_ready_o      = cfg_ready;
  assign patch_in_ready_o = patch_ready;
  assign node_wdata_o     = wdata_q;
  assign root_valid_o     = root_valid_q;
  assign root_patch_o     = root_patch_q;
  assign loaded_o         = loaded_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_kd_tree_node_ctrl.sv
// Self-checking bench for kd_tree_node_ctrl. Expected node writes and root
// patches are queued when stimulus is driven; negedge monitors pop and compare
// them whenever the DUT pulses node_wen or root_valid.
module tb_kd_tree_node_ctrl;

  localparam int unsigned DataW  = 55;
  localparam int unsigned StoreW = 22;
  localparam int unsigned NumN   = 15;
  localparam int unsigned DrainC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_load = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [StoreW-1:0] cfg_data = '0;
  logic              cfg_ready;
  logic [NumN-1:0]   node_wen;
  logic [StoreW-1:0] node_wdata;
  logic              patch_in_valid = 1'b0;
  logic [DataW-1:0]  patch_in = '0;
  logic              patch_in_ready;
  logic              root_valid;
  logic [DataW-1:0]  root_patch;
  logic              loaded;
  logic              busy;

  typedef struct {
    int unsigned       idx;
    logic [StoreW-1:0] data;
  } wr_exp_t;

  wr_exp_t          wr_q[$];
  logic [DataW-1:0] patch_q[$];
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  kd_tree_node_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_load_i    (start_load),
    .cfg_valid_i     (cfg_valid),
    .cfg_data_i      (cfg_data),
    .cfg_ready_o     (cfg_ready),
    .node_wen_o      (node_wen),
    .node_wdata_o    (node_wdata),
    .patch_in_valid_i(patch_in_valid),
    .patch_in_i      (patch_in),
    .patch_in_ready_o(patch_in_ready),
    .root_valid_o    (root_valid),
    .root_patch_o    (root_patch),
    .loaded_o        (loaded),
    .busy_o          (busy)
  );

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (!rst) begin
      if (node_wen !== '0) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wen_unexpected got wen=%h wdata=%h required none", node_wen, node_wdata);
        end else begin
          wr_exp_t         e;
          logic [NumN-1:0] wen_exp;
          e = wr_q.pop_front();
          wen_exp = '0;
          wen_exp[e.idx] = 1'b1;
          if (node_wen !== wen_exp || node_wdata !== e.data) begin
            errors++;
            $display("FAIL node_write got wen=%h wdata=%h required wen=%h wdata=%h",
                     node_wen, node_wdata, wen_exp, e.data);
          end
        end
      end
      if (root_valid !== 1'b0) begin
        checks++;
        if (patch_q.size() == 0) begin
          errors++;
          $display("FAIL root_unexpected got valid=%b patch=%h required none",
                   root_valid, root_patch);
        end else begin
          logic [DataW-1:0] p;
          p = patch_q.pop_front();
          if (root_valid !== 1'b1 || root_patch !== p) begin
            errors++;
            $display("FAIL root_patch got %h required %h", root_patch, p);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
  endtask

  task automatic load_words(input int unsigned first, input int unsigned last,
                            input int unsigned base);
    for (int unsigned i = first; i <= last; i++) begin
      wr_exp_t e;
      cfg_valid = 1'b1;
      cfg_data  = StoreW'(base + i);
      e.idx = i;
      e.data = StoreW'(base + i);
      wr_q.push_back(e);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b1;
    patch_in_valid = 1'b1;
    patch_in = 55'h1234;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({cfg_ready, node_wen, node_wdata, patch_in_ready, root_valid, root_patch, loaded, busy}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cfg_rdy=%b wen=%h wd=%h p_rdy=%b rv=%b rp=%h ld=%b bz=%b",
               cfg_ready, node_wen, node_wdata, patch_in_ready, root_valid, root_patch,
               loaded, busy);
    end
    step();
    rst = 1'b0;
    cfg_valid = 1'b0;
    // Patches stay valid while idle; none may reach the root.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b0 || node_wen !== '0 || root_valid !== 1'b0 || patch_in_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL idle_gating got cfg_rdy=%b wen=%h rv=%b p_rdy=%b required 0 0 0 0",
                 cfg_ready, node_wen, root_valid, patch_in_ready);
      end
      step();
    end
    patch_in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    pulse_start();
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_entry got cfg_rdy=%b busy=%b required 1 1", cfg_ready, busy);
    end
    load_words(0, NumN - 1, 1);
    // Extra word offered in the cycle of the last write must be refused.
    cfg_valid = 1'b1;
    cfg_data  = 22'h3ff99;
    @(negedge clk);
    checks++;
    if (loaded !== 1'b1 || node_wen !== 15'h4000 || patch_in_ready !== 1'b1 || busy !== 1'b0)
    begin
      errors++;
      $display("FAIL last_write got ld=%b wen=%h p_rdy=%b busy=%b required 1 4000 1 0",
               loaded, node_wen, patch_in_ready, busy);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ready_run got %b required 0", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (node_wen !== '0) begin
      errors++;
      $display("FAIL extra_word got wen=%h required 0", node_wen);
    end
    step();
  endtask

  task automatic test_patch();
    patch_in_valid = 1'b1;
    patch_in = 55'h60_0C01_8010_03;
    patch_q.push_back(55'h60_0C01_8010_03);
    step();
    patch_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (root_valid !== 1'b1 || root_patch !== 55'h60_0C01_8010_03) begin
      errors++;
      $display("FAIL first_patch got rv=%b rp=%h required 1 600c01801003", root_valid, root_patch);
    end
    step();
    // Back-to-back patches.
    for (int k = 0; k < 5; k++) begin
      logic [DataW-1:0] p;
      p = {$urandom(), $urandom()};
      patch_in_valid = 1'b1;
      patch_in = p;
      patch_q.push_back(p);
      step();
    end
    patch_in_valid = 1'b0;
    patch_in = '1;
    step();
    @(negedge clk);
    checks++;
    if (root_valid !== 1'b0 || patch_q.size() != 0) begin
      errors++;
      $display("FAIL patch_drain got rv=%b pending=%0d required 0 0", root_valid, patch_q.size());
    end
  endtask

  task automatic test_reload_drain();
    step();
    start_load = 1'b1;
    patch_in_valid = 1'b1;
    patch_in = 55'h7_7777;
    @(negedge clk);
    checks++;
    if (patch_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_ready got %b required 0", patch_in_ready);
    end
    step();
    start_load = 1'b0;
    for (int k = 0; k < int'(DrainC); k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || loaded !== 1'b0 || cfg_ready !== 1'b0 || root_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_cycle%0d got bz=%b ld=%b cfg_rdy=%b rv=%b required 1 0 0 0",
                 k, busy, loaded, cfg_ready, root_valid);
      end
      step();
    end
    patch_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_exit got cfg_rdy=%b busy=%b required 1 1", cfg_ready, busy);
    end
  endtask

  task automatic test_stalled_load();
    load_words(0, 5, 22'h100);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (node_wen !== '0) begin
        errors++;
        $display("FAIL stall_gap%0d got wen=%h required 0", k, node_wen);
      end
    end
    step();
    load_words(6, 6, 22'h100);
    @(negedge clk);
    checks++;
    if (node_wen !== 15'h0040 || node_wdata !== 22'h106) begin
      errors++;
      $display("FAIL resume_node got wen=%h wd=%h required 0040 106", node_wen, node_wdata);
    end
    step();
    load_words(7, NumN - 1, 22'h100);
    step();
    @(negedge clk);
    checks++;
    if (loaded !== 1'b1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL stalled_done got ld=%b pending=%0d required 1 0", loaded, wr_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int unsigned budget;
    step();
    pulse_start();
    budget = 0;
    while (cfg_ready !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_timeout got cfg_rdy=%b required 1", cfg_ready);
    end
    load_words(0, 6, 22'h200);
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0 || node_wen !== '0) begin
      errors++;
      $display("FAIL mid_reset got cfg_rdy=%b bz=%b ld=%b wen=%h required 0 0 0 0",
               cfg_ready, busy, loaded, node_wen);
    end
    step();
    rst = 1'b0;
    step();
    pulse_start();
    load_words(0, 0, 22'h0abc);
    @(negedge clk);
    checks++;
    if (node_wen !== 15'h0001 || node_wdata !== 22'h0abc) begin
      errors++;
      $display("FAIL restart_node0 got wen=%h wd=%h required 0001 0abc", node_wen, node_wdata);
    end
    step();
    step();
    checks++;
    if (wr_q.size() != 0 || patch_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got wr=%0d patch=%0d required 0 0",
               wr_q.size(), patch_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_patch();
    test_reload_drain();
    test_stalled_load();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
